// File: rtl/xsz_dn_seq.sv
// Sequencing downsizer: splits one wide beat into a burst of narrow lane beats, starting at the
// address-selected lane. Define XSZ_DN_SEQ_SKIP_EN to skip lanes whose strobe slice is all zero.
module xsz_dn_seq #(
  parameter int unsigned A  = 19,
  parameter int unsigned H  = 8,
  parameter int unsigned DI = 128,
  parameter int unsigned DO = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_vld,
  output logic            s_rdy,
  input  logic [H-1:0]    s_hdr,
  input  logic [A-1:0]    s_adr,
  input  logic [DI/8-1:0] s_stb,
  input  logic [DI-1:0]   s_dat,
  output logic            m_vld,
  input  logic            m_rdy,
  output logic [H-1:0]    m_hdr,
  output logic [A-1:0]    m_adr,
  output logic [DO/8-1:0] m_stb,
  output logic [DO-1:0]   m_dat,
  output logic            m_last
);

  localparam int unsigned R  = DI / DO;
  localparam int unsigned LO = $clog2(DO / 8);
  localparam int unsigned LI = $clog2(DI / 8);
  localparam int unsigned LW = $clog2(R);
  localparam int unsigned SB = DO / 8;

  typedef enum logic {StIdle, StSplit} state_e;

  state_e            state_q, state_d;
  logic [LW-1:0]     lane_q;
  logic [H-1:0]      hdr_q;
  logic [A-1:0]      adr_q;
  logic [DI/8-1:0]   stb_q;
  logic [DI-1:0]     dat_q;
  logic [H-1:0]      m_hdr_q;
  logic [A-1:0]      m_adr_q;
  logic [DO/8-1:0]   m_stb_q;
  logic [DO-1:0]     m_dat_q;
  logic              m_last_q;

  logic              accept, take, cap_en, out_en;
  logic [H-1:0]      src_hdr;
  logic [A-1:0]      src_adr;
  logic [DI/8-1:0]   src_stb;
  logic [DI-1:0]     src_dat;
  logic [LW-1:0]     start, base, sel;
  logic              sel_last;
  logic [A-1:0]      sel_adr;

  assign m_vld  = (state_q == StSplit);
  assign m_hdr  = m_hdr_q;
  assign m_adr  = m_adr_q;
  assign m_stb  = m_stb_q;
  assign m_dat  = m_dat_q;
  assign m_last = m_last_q;

  assign s_rdy  = (state_q == StIdle) || (m_vld && m_rdy && m_last_q);
  assign accept = s_vld && s_rdy;
  assign take   = m_vld && m_rdy;

  // Next lane to present: drawn from the incoming beat on accept, else from the capture register.
  always_comb begin
    src_hdr = accept ? s_hdr : hdr_q;
    src_adr = accept ? s_adr : adr_q;
    src_stb = accept ? s_stb : stb_q;
    src_dat = accept ? s_dat : dat_q;
    start   = s_adr[LI-1:LO];
    base    = accept ? start : lane_q + LW'(1);
`ifdef XSZ_DN_SEQ_SKIP_EN
    sel = base;
    for (int i = R - 1; i >= 0; i--) begin
      if (i >= int'(base) && (|src_stb[i*SB +: SB])) sel = LW'(i);
    end
    sel_last = 1'b1;
    for (int i = 0; i < R; i++) begin
      if (i > int'(sel) && (|src_stb[i*SB +: SB])) sel_last = 1'b0;
    end
`else
    sel      = base;
    sel_last = (sel == LW'(R - 1));
`endif
    // Only a burst's first beat on its start lane keeps the unaligned byte address.
    sel_adr = (accept && sel == start) ? src_adr : {src_adr[A-1:LI], sel, {LO{1'b0}}};
  end

  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    out_en  = 1'b0;
    if (accept) begin
      state_d = StSplit;
      cap_en  = 1'b1;
      out_en  = 1'b1;
    end else if (take && m_last_q) begin
      state_d = StIdle;
    end else if (take) begin
      out_en = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      lane_q   <= '0;
      hdr_q    <= '0;
      adr_q    <= '0;
      stb_q    <= '0;
      dat_q    <= '0;
      m_hdr_q  <= '0;
      m_adr_q  <= '0;
      m_stb_q  <= '0;
      m_dat_q  <= '0;
      m_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cap_en) begin
        hdr_q <= s_hdr;
        adr_q <= s_adr;
        stb_q <= s_stb;
        dat_q <= s_dat;
      end
      if (out_en) begin
        lane_q   <= sel;
        m_hdr_q  <= src_hdr;
        m_adr_q  <= sel_adr;
        m_stb_q  <= src_stb[sel*SB +: SB];
        m_dat_q  <= src_dat[sel*DO +: DO];
        m_last_q <= sel_last;
      end
    end
  end

endmodule

// File: tb/tb_xsz_dn_seq.sv
// Directed bench for xsz_dn_seq (DI=128, DO=32): unaligned start, backpressure, back-to-back,
// strobe skipping, empty strobe and mid-burst reset.
module tb_xsz_dn_seq;

  localparam logic [127:0] DAT = {32'hCAFE0003, 32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_vld, s_rdy, m_vld, m_rdy, m_last;
  logic [7:0]   s_hdr, m_hdr;
  logic [18:0]  s_adr, m_adr;
  logic [15:0]  s_stb;
  logic [127:0] s_dat;
  logic [3:0]   m_stb;
  logic [31:0]  m_dat;
  logic [7:0]   exp_hdr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  xsz_dn_seq dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_vld  (s_vld),
    .s_rdy  (s_rdy),
    .s_hdr  (s_hdr),
    .s_adr  (s_adr),
    .s_stb  (s_stb),
    .s_dat  (s_dat),
    .m_vld  (m_vld),
    .m_rdy  (m_rdy),
    .m_hdr  (m_hdr),
    .m_adr  (m_adr),
    .m_stb  (m_stb),
    .m_dat  (m_dat),
    .m_last (m_last)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one input beat; the block must be ready for it.
  task automatic send(input logic [18:0] adr, input logic [15:0] stb, input logic [7:0] hdr);
    check("send_rdy", s_rdy, 1'b1);
    s_vld   = 1'b1;
    s_adr   = adr;
    s_stb   = stb;
    s_hdr   = hdr;
    s_dat   = DAT;
    exp_hdr = hdr;
    step();
    s_vld = 1'b0;
  endtask

  // Check the currently presented narrow beat, then advance one cycle.
  task automatic beat(input string tag, input logic [18:0] adr, input logic [31:0] dat,
                      input logic [3:0] stb, input logic last);
    check({tag, "_vld"}, m_vld, 1'b1);
    check({tag, "_adr"}, m_adr, adr);
    check({tag, "_dat"}, m_dat, dat);
    check({tag, "_stb"}, m_stb, stb);
    check({tag, "_last"}, m_last, last);
    check({tag, "_hdr"}, m_hdr, exp_hdr);
    check({tag, "_srdy"}, s_rdy, last & m_rdy);
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    s_vld = 1'b0;
    s_hdr = '0;
    s_adr = '0;
    s_stb = '0;
    s_dat = '0;
    m_rdy = 1'b1;
    exp_hdr = '0;
    step();
    step();
    rst_n = 1'b1;
    step();

    check("rst_vld", m_vld, 1'b0);
    check("rst_last", m_last, 1'b0);
    check("rst_adr", m_adr, 19'h0);
    check("rst_dat", m_dat, 32'h0);
    check("rst_srdy", s_rdy, 1'b1);

    // Unaligned start at lane 1
    send(19'h00004, 16'hFFFF, 8'h5A);
    beat("ua1", 19'h4, 32'hCAFE0001, 4'hF, 1'b0);
    beat("ua2", 19'h8, 32'hCAFE0002, 4'hF, 1'b0);
    beat("ua3", 19'hC, 32'hCAFE0003, 4'hF, 1'b1);
    check("ua_idle", m_vld, 1'b0);

    // Backpressure on the second beat
    send(19'h00000, 16'hFFFF, 8'hA5);
    beat("bp1", 19'h0, 32'hCAFE0000, 4'hF, 1'b0);
    m_rdy = 1'b0;
    for (int i = 0; i < 3; i++) beat("bp_hold", 19'h4, 32'hCAFE0001, 4'hF, 1'b0);
    m_rdy = 1'b1;
    beat("bp2", 19'h4, 32'hCAFE0001, 4'hF, 1'b0);
    beat("bp3", 19'h8, 32'hCAFE0002, 4'hF, 1'b0);
    beat("bp4", 19'hC, 32'hCAFE0003, 4'hF, 1'b1);
    check("bp_idle", m_vld, 1'b0);

    // Back-to-back bursts with s_vld held
    exp_hdr = 8'h11;
    s_hdr = 8'h11;
    s_vld = 1'b1;
    s_adr = 19'h00000;
    s_stb = 16'hFFFF;
    s_dat = DAT;
    step();
    s_adr = 19'h00010;
    s_hdr = 8'h22;
    beat("bb1", 19'h00, 32'hCAFE0000, 4'hF, 1'b0);
    beat("bb2", 19'h04, 32'hCAFE0001, 4'hF, 1'b0);
    beat("bb3", 19'h08, 32'hCAFE0002, 4'hF, 1'b0);
    beat("bb4", 19'h0C, 32'hCAFE0003, 4'hF, 1'b1);
    s_vld = 1'b0;
    exp_hdr = 8'h22;
    beat("bb5", 19'h10, 32'hCAFE0000, 4'hF, 1'b0);
    beat("bb6", 19'h14, 32'hCAFE0001, 4'hF, 1'b0);
    beat("bb7", 19'h18, 32'hCAFE0002, 4'hF, 1'b0);
    beat("bb8", 19'h1C, 32'hCAFE0003, 4'hF, 1'b1);
    check("bb_idle", m_vld, 1'b0);

    // Sparse strobes
    send(19'h00000, 16'h0F0F, 8'h33);
`ifdef XSZ_DN_SEQ_SKIP_EN
    beat("sk1", 19'h0, 32'hCAFE0000, 4'hF, 1'b0);
    beat("sk2", 19'h8, 32'hCAFE0002, 4'hF, 1'b1);
`else
    beat("sk1", 19'h0, 32'hCAFE0000, 4'hF, 1'b0);
    beat("sk2", 19'h4, 32'hCAFE0001, 4'h0, 1'b0);
    beat("sk3", 19'h8, 32'hCAFE0002, 4'hF, 1'b0);
    beat("sk4", 19'hC, 32'hCAFE0003, 4'h0, 1'b1);
`endif
    check("sk_idle", m_vld, 1'b0);

    // Empty strobe from lane 2
    send(19'h00008, 16'h0000, 8'h44);
`ifdef XSZ_DN_SEQ_SKIP_EN
    beat("em1", 19'h8, 32'hCAFE0002, 4'h0, 1'b1);
`else
    beat("em1", 19'h8, 32'hCAFE0002, 4'h0, 1'b0);
    beat("em2", 19'hC, 32'hCAFE0003, 4'h0, 1'b1);
`endif
    check("em_idle", m_vld, 1'b0);

    // Reset asserted after the first of four beats
    send(19'h00000, 16'hFFFF, 8'h55);
    beat("rs1", 19'h0, 32'hCAFE0000, 4'hF, 1'b0);
    check("rs_pre_vld", m_vld, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rs_async_vld", m_vld, 1'b0);
    check("rs_async_adr", m_adr, 19'h0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("rs_post_vld", m_vld, 1'b0);
      check("rs_post_srdy", s_rdy, 1'b1);
      step();
    end
    exp_hdr = 8'h00;
    send(19'h0000C, 16'hFFFF, 8'h66);
    beat("rs_new", 19'hC, 32'hCAFE0003, 4'hF, 1'b1);
    check("rs_new_idle", m_vld, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
